// File: rtl/regfile_wb_sched_pkg.sv
// ============================================================================
// Module      : regfile_wb_sched_pkg
// Description : Shared widths, constants and FSM encoding for the writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_sched_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO_IDX   = 0;

    typedef enum logic [1:0] {
        WBS_IDLE = 2'd0,
        WBS_BUSY = 2'd1,
        WBS_HOLD = 2'd2
    } wb_sched_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_sched_hazard_cmp.sv
// ============================================================================
// Module      : regfile_wb_sched_hazard_cmp
// Description : Decode-vs-scoreboard comparator producing RAW and WAW flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_sched_hazard_cmp
    import regfile_wb_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_pend_rd,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    input  logic                  i_use_rs1,
    input  logic                  i_use_rs2,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic                  i_wen,
    output logic                  o_raw,
    output logic                  o_waw
);

    localparam logic [ADDR_WIDTH-1:0] c_REG_ZERO = ADDR_WIDTH'(REG_ZERO_IDX);

    logic w_live;

    // x0 is never a real dependency, so a pending x0 result blocks nothing
    assign w_live = i_en && (i_pend_rd != c_REG_ZERO);

    assign o_raw = w_live && ((i_use_rs1 && (i_rs1 == i_pend_rd)) ||
                              (i_use_rs2 && (i_rs2 == i_pend_rd)));
    assign o_waw = w_live && i_wen && (i_rd == i_pend_rd);

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
// ============================================================================
// Module      : regfile_wb_sched
// Description : Arbitrates the register-bank write port between pipeline
//               writeback and the MDU, with a one-entry MDU scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wen_i,
    input  logic [ADDR_WIDTH-1:0] pipe_waddr_i,
    input  logic [WORD_WIDTH-1:0] pipe_wdata_i,
    input  logic                  mdu_issue_i,
    input  logic [ADDR_WIDTH-1:0] mdu_rd_i,
    input  logic                  mdu_valid_i,
    input  logic [WORD_WIDTH-1:0] mdu_wdata_i,
    output logic                  mdu_ready_o,
    input  logic [ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_i,
    input  logic                  id_wen_i,
    output logic                  reg_wen_o,
    output logic [ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [WORD_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_o,
    output logic                  mdu_busy_o
);

    localparam logic [ADDR_WIDTH-1:0] c_REG_ZERO = ADDR_WIDTH'(REG_ZERO_IDX);

    wb_sched_state_e       r_state;
    logic [ADDR_WIDTH-1:0] r_pend_rd;
    logic [WORD_WIDTH-1:0] r_hold_data;

    logic w_busy;
    logic w_hold;
    logic w_pend_nz;
    logic w_pipe_wr;
    logic w_port_free;
    logic w_mdu_direct;
    logic w_mdu_held;
    logic w_wen;
    logic w_raw;
    logic w_waw;
    logic w_stall;

    assign w_busy      = (r_state != WBS_IDLE);
    assign w_hold      = (r_state == WBS_HOLD);
    assign w_pend_nz   = (r_pend_rd != c_REG_ZERO);
    // Pipeline writes to x0 are no-ops, so they leave the port free for the MDU
    assign w_pipe_wr   = pipe_wen_i && (pipe_waddr_i != c_REG_ZERO);
    assign w_port_free = !w_pipe_wr;

    assign w_mdu_direct = (r_state == WBS_BUSY) && mdu_valid_i && w_pend_nz && w_port_free;
    assign w_mdu_held   = w_hold && w_port_free;

    regfile_wb_sched_hazard_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hazard_cmp (
        .i_en      (w_busy),
        .i_pend_rd (r_pend_rd),
        .i_rs1     (id_rs1_i),
        .i_rs2     (id_rs2_i),
        .i_use_rs1 (id_use_rs1_i),
        .i_use_rs2 (id_use_rs2_i),
        .i_rd      (id_rd_i),
        .i_wen     (id_wen_i),
        .o_raw     (w_raw),
        .o_waw     (w_waw)
    );

    // Depends only on registered state and decode fields, never on mdu_valid_i
    assign w_stall = w_raw || w_waw || (w_busy && mdu_issue_i) || w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WBS_IDLE;
            r_pend_rd   <= c_REG_ZERO;
            r_hold_data <= '0;
        end else begin
            case (r_state)
                WBS_IDLE: begin
                    if (mdu_issue_i && !w_stall) begin
                        r_state   <= WBS_BUSY;
                        r_pend_rd <= mdu_rd_i;
                    end
                end
                WBS_BUSY: begin
                    if (mdu_valid_i) begin
                        if (!w_pend_nz || w_port_free) begin
                            r_state   <= WBS_IDLE;
                            r_pend_rd <= c_REG_ZERO;
                        end else begin
                            r_state     <= WBS_HOLD;
                            r_hold_data <= mdu_wdata_i;
                        end
                    end
                end
                WBS_HOLD: begin
                    if (w_port_free) begin
                        r_state   <= WBS_IDLE;
                        r_pend_rd <= c_REG_ZERO;
                    end
                end
                default: begin
                    r_state   <= WBS_IDLE;
                    r_pend_rd <= c_REG_ZERO;
                end
            endcase
        end
    end

    // Pipeline path is gated by rst_n so every output is quiet while reset is held
    assign w_wen = (rst_n && w_pipe_wr) || w_mdu_direct || w_mdu_held;

    assign reg_wen_o   = w_wen;
    assign reg_waddr_o = !w_wen    ? c_REG_ZERO   :
                         w_pipe_wr ? pipe_waddr_i : r_pend_rd;
    assign reg_wdata_o = !w_wen    ? '0           :
                         w_pipe_wr ? pipe_wdata_i :
                         w_hold    ? r_hold_data  : mdu_wdata_i;

    assign stall_o     = w_stall;
    assign mdu_ready_o = !w_hold;
    assign mdu_busy_o  = w_busy;

    a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
        reg_wen_o |-> (reg_waddr_o != c_REG_ZERO));

    a_valid_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == WBS_IDLE) && mdu_valid_i));

    a_one_write_per_issue: assert property (@(posedge clk) disable iff (!rst_n)
        (w_mdu_direct || w_mdu_held) |=> (r_state == WBS_IDLE));

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Directed plus randomized bench against a behavioural scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mdu_issue;
    logic [4:0]  mdu_rd;
    logic        mdu_valid;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        stall;
    logic        mdu_busy;

    int n_vec = 0;
    int n_err = 0;

    // Model: outstanding MDU destination (-1 = none) and results waiting for the port
    int          m_out = -1;
    logic [31:0] m_held[$];

    regfile_wb_sched #(
        .WORD_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wen_i   (pipe_wen),
        .pipe_waddr_i (pipe_waddr),
        .pipe_wdata_i (pipe_wdata),
        .mdu_issue_i  (mdu_issue),
        .mdu_rd_i     (mdu_rd),
        .mdu_valid_i  (mdu_valid),
        .mdu_wdata_i  (mdu_wdata),
        .mdu_ready_o  (mdu_ready),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .id_rd_i      (id_rd),
        .id_wen_i     (id_wen),
        .reg_wen_o    (reg_wen),
        .reg_waddr_o  (reg_waddr),
        .reg_wdata_o  (reg_wdata),
        .stall_o      (stall),
        .mdu_busy_o   (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_in();
        pipe_wen = 0; pipe_waddr = 0; pipe_wdata = 0;
        mdu_issue = 0; mdu_rd = 0; mdu_valid = 0; mdu_wdata = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_wen = 0;
    endtask

    function automatic bit m_pipe_wr();
        return pipe_wen && (pipe_waddr != 0);
    endfunction

    // Wait to mid-cycle and compare every output against the model
    task automatic settle();
        bit          out, held, direct, hwr, ewen, est;
        int          pr;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        @(negedge clk);
        out    = (m_out >= 0);
        held   = (m_held.size() > 0);
        pr     = m_out;
        direct = out && !held && mdu_valid && (pr != 0) && !m_pipe_wr();
        hwr    = held && !m_pipe_wr();
        ewen   = m_pipe_wr() || direct || hwr;
        eaddr  = m_pipe_wr() ? pipe_waddr : 5'(pr);
        edata  = m_pipe_wr() ? pipe_wdata : (held ? m_held[0] : mdu_wdata);
        est    = held || (out && mdu_issue) ||
                 (out && pr != 0 && ((id_use_rs1 && int'(id_rs1) == pr) ||
                                     (id_use_rs2 && int'(id_rs2) == pr) ||
                                     (id_wen && int'(id_rd) == pr)));
        chk("wen", 32'(reg_wen), 32'(ewen));
        if (ewen) begin
            chk("waddr", 32'(reg_waddr), 32'(eaddr));
            chk("wdata", reg_wdata, edata);
        end
        chk("stall", 32'(stall), 32'(est));
        chk("ready", 32'(mdu_ready), 32'(!held));
        chk("busy", 32'(mdu_busy), 32'(out));
    endtask

    // Advance the model by one clock edge, then move to just after that edge
    task automatic commit();
        bit out, held;
        out  = (m_out >= 0);
        held = (m_held.size() > 0);
        if (!out) begin
            if (mdu_issue) m_out = int'(mdu_rd);
        end else if (held) begin
            if (!m_pipe_wr()) begin
                void'(m_held.pop_front());
                m_out = -1;
            end
        end else if (mdu_valid) begin
            if (m_out == 0 || !m_pipe_wr()) m_out = -1;
            else m_held.push_back(mdu_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        #12;
        chk("rst_ready", 32'(mdu_ready), 32'd1);
        chk("rst_wen", 32'(reg_wen), 32'd0);
        chk("rst_busy", 32'(mdu_busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Basic MDU completion to x5
        idle_in(); mdu_issue = 1; mdu_rd = 5;
        settle(); chk("t1_issue_stall", 32'(stall), 32'd0); commit();
        idle_in();
        repeat (3) begin settle(); chk("t1_busy", 32'(mdu_busy), 32'd1); commit(); end
        mdu_valid = 1; mdu_wdata = 32'h0000_00AB;
        settle();
        chk("t1_wen", 32'(reg_wen), 32'd1);
        chk("t1_addr", 32'(reg_waddr), 32'd5);
        chk("t1_data", reg_wdata, 32'h0000_00AB);
        commit();
        idle_in(); settle(); chk("t1_idle", 32'(mdu_busy), 32'd0); commit();

        // RAW on pending x7
        mdu_issue = 1; mdu_rd = 7; settle(); commit();
        idle_in(); id_rs2 = 7; id_use_rs2 = 1;
        repeat (2) begin settle(); chk("t2_raw", 32'(stall), 32'd1); commit(); end
        id_use_rs2 = 0; id_rs1 = 8; id_use_rs1 = 1;
        settle(); chk("t2_norel", 32'(stall), 32'd0); commit();
        id_use_rs2 = 1; mdu_valid = 1; mdu_wdata = 32'h77;
        settle(); chk("t2_prewrite", 32'(stall), 32'd1); chk("t2_wr", 32'(reg_waddr), 32'd7); commit();
        mdu_valid = 0;
        settle(); chk("t2_release", 32'(stall), 32'd0); commit();

        // Port contention -> HOLD
        idle_in(); mdu_issue = 1; mdu_rd = 3; settle(); commit();
        idle_in(); mdu_valid = 1; mdu_wdata = 32'h1234;
        pipe_wen = 1; pipe_waddr = 9; pipe_wdata = 32'h55;
        settle(); chk("t3_pipe_addr", 32'(reg_waddr), 32'd9); chk("t3_pipe_data", reg_wdata, 32'h55); commit();
        idle_in();
        settle();
        chk("t3_ready", 32'(mdu_ready), 32'd0);
        chk("t3_stall", 32'(stall), 32'd1);
        chk("t3_haddr", 32'(reg_waddr), 32'd3);
        chk("t3_hdata", reg_wdata, 32'h1234);
        commit();
        settle(); chk("t3_idle", 32'(mdu_busy), 32'd0); commit();

        // MDU op to x0 with pipeline write to x0
        mdu_issue = 1; mdu_rd = 0; settle(); commit();
        idle_in(); mdu_valid = 1; mdu_wdata = 32'hFFFF_FFFF; pipe_wen = 1; pipe_waddr = 0;
        settle(); chk("t4_wen", 32'(reg_wen), 32'd0); commit();
        idle_in(); settle(); chk("t4_idle", 32'(mdu_busy), 32'd0); commit();

        // Structural stall on second issue
        mdu_issue = 1; mdu_rd = 4; settle(); commit();
        mdu_rd = 6; settle(); chk("t5_struct", 32'(stall), 32'd1); commit();
        idle_in(); mdu_valid = 1; mdu_wdata = 32'hC0DE;
        settle(); chk("t5_pend", 32'(reg_waddr), 32'd4); commit();
        idle_in(); mdu_issue = 1; mdu_rd = 6;
        settle(); chk("t5_reissue", 32'(stall), 32'd0); commit();
        idle_in(); mdu_valid = 1; mdu_wdata = 32'hBEEF;
        settle(); chk("t5_addr2", 32'(reg_waddr), 32'd6); commit();
        idle_in();

        // Asynchronous reset while in HOLD
        mdu_issue = 1; mdu_rd = 10; settle(); commit();
        idle_in(); mdu_valid = 1; mdu_wdata = 32'hDEAD; pipe_wen = 1; pipe_waddr = 9;
        settle(); commit();
        idle_in(); pipe_wen = 1; pipe_waddr = 11; pipe_wdata = 32'h1;
        settle();
        rst_n = 0;
        #1;
        chk("t6_wen", 32'(reg_wen), 32'd0);
        chk("t6_ready", 32'(mdu_ready), 32'd1);
        chk("t6_busy", 32'(mdu_busy), 32'd0);
        chk("t6_stall", 32'(stall), 32'd0);
        m_out = -1;
        m_held.delete();
        idle_in();
        @(posedge clk); #3;
        rst_n = 1;
        repeat (4) begin settle(); chk("t6_nowrite", 32'(reg_wen), 32'd0); commit(); end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            idle_in();
            pipe_wen   = ($urandom_range(0, 99) < 40);
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            mdu_issue  = ($urandom_range(0, 99) < 25);
            mdu_rd     = 5'($urandom_range(0, 7));
            if (m_out >= 0) mdu_valid = ($urandom_range(0, 99) < 35);
            mdu_wdata  = $urandom;
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            id_rd      = 5'($urandom_range(0, 7));
            id_wen     = 1'($urandom);
            settle();
            commit();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Schedules the single register-bank write port between the in-order pipeline writeback and the multi-cycle multiply/divide unit (MDU) result.
- Keeps a one-entry scoreboard for the in-flight MDU destination register.
- Stalls the decode stage on RAW/WAW hazards and on port contention.
- Sits between the writeback stage, the MDU and the register-bank write inputs (write_addr, write_data, write_en).

Parameters:
- WORD_WIDTH, 32, data width of register-bank writes.
- ADDR_WIDTH, 5, register address width; x0 is address 0.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- pipe_wen_i  input  1  pipeline writeback request
- pipe_waddr_i  input  ADDR_WIDTH  pipeline destination register
- pipe_wdata_i  input  WORD_WIDTH  pipeline writeback data
- mdu_issue_i  input  1  decode issues an MDU op this cycle (qualified by !stall_o)
- mdu_rd_i  input  ADDR_WIDTH  destination of the issued MDU op
- mdu_valid_i  input  1  MDU result valid
- mdu_wdata_i  input  WORD_WIDTH  MDU result data
- mdu_ready_o  output  1  result accepted when mdu_valid_i && mdu_ready_o
- id_rs1_i, id_rs2_i  input  ADDR_WIDTH  decode source registers
- id_use_rs1_i, id_use_rs2_i  input  1  the decode instruction reads rs1/rs2
- id_rd_i  input  ADDR_WIDTH  decode destination register
- id_wen_i  input  1  the decode instruction writes rd
- reg_wen_o  output  1  register-bank write enable
- reg_waddr_o  output  ADDR_WIDTH  register-bank write address
- reg_wdata_o  output  WORD_WIDTH  register-bank write data
- stall_o  output  1  hold fetch/decode this cycle
- mdu_busy_o  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pend_rd=0, hold_data=0.
  - All outputs 0, except mdu_ready_o=1.
  - Reset mid-operation discards any in-flight or held result; no write is issued.
- FSM states:
  - IDLE: no MDU op outstanding.
    - mdu_issue_i && !stall_o -> BUSY, pend_rd<=mdu_rd_i.
  - BUSY: awaiting result; mdu_ready_o=1.
    - If mdu_valid_i and the port is free (pipe_wen_i=0 or pipe_waddr_i=0): write the MDU result this cycle -> IDLE.
    - If mdu_valid_i and the port is busy: hold_data<=mdu_wdata_i -> HOLD.
  - HOLD: mdu_ready_o=0.
    - Held result is written on the first cycle the port is free -> IDLE.
- pend_rd=0 (MDU op targeting x0): the result is accepted and discarded; no write; -> IDLE.
- Write-port mux (combinational, zero latency):
  - A pipeline write to a nonzero address always wins.
  - Otherwise, an MDU write (direct or held) to pend_rd.
  - Otherwise reg_wen_o=0.
  - Writes to x0 never raise reg_wen_o; reg_waddr_o/reg_wdata_o are don't-care when reg_wen_o=0.
- stall_o is the OR of:
  - RAW: state!=IDLE && pend_rd!=0 && ((id_use_rs1_i && id_rs1_i==pend_rd) || (id_use_rs2_i && id_rs2_i==pend_rd)).
  - WAW: state!=IDLE && id_wen_i && id_rd_i==pend_rd && pend_rd!=0.
  - Structural: state!=IDLE && mdu_issue_i (one MDU op outstanding maximum).
  - Contention: state==HOLD (the pipeline drains until the port is free).
- The scoreboard clears on the clock edge that performs the MDU write; the decode stall drops the following cycle.
- No combinational path from mdu_valid_i to stall_o in the same cycle the write occurs; stall_o still reflects the pre-write state.
- mdu_issue_i while stall_o=1 is ignored. mdu_valid_i in IDLE is a protocol error: ignored, and flagged by an assertion.
- Assertions:
  - reg_wen_o implies reg_waddr_o!=0.
  - Never more than one MDU result written per issue.

Decomposition:
- riscv_defines: WORD_WIDTH, ADDR_WIDTH, REG_ZERO constant.
- ctrl_typedefs: enum wb_sched_state {WBS_IDLE, WBS_BUSY, WBS_HOLD}.
- One sub-module, hazard_cmp: pure combinational comparator producing raw/waw flags from the decode fields and pend_rd. It is reusable for a later forwarding unit.
- FSM and write mux stay in the top module.

Test Plan:
- Issue MDU op rd=5 from IDLE; mdu_valid_i=1 with data 0x0000_00AB after 4 cycles, pipe_wen_i=0 -> reg_wen_o=1, waddr=5, wdata=0xAB that cycle; next cycle state IDLE, mdu_busy_o=0.
- Pending rd=7; decode presents rs2=7, use_rs2=1 -> stall_o=1 every cycle until the cycle after the MDU write to x7; rs1=8 alone -> stall_o=0.
- Result 0x1234 for rd=3 arrives together with a pipe write rd=9 data 0x55 -> x9 written first; HOLD with mdu_ready_o=0 and stall_o=1. Next cycle pipe_wen_i=0 -> x3<=0x1234 -> IDLE.
- MDU op with rd=0 and result 0xFFFF_FFFF; pipe write to x0 -> reg_wen_o stays 0 throughout; FSM returns to IDLE.
- Second mdu_issue_i while BUSY -> stall_o=1 and pend_rd unchanged; after completion, reissue is accepted the next cycle.
- In HOLD, assert rst_n=0 asynchronously -> outputs clear immediately; after release, no write to the held register ever occurs.
